// File: rtl/behav_sram_pkg.sv
// Shared types and helpers for the behavioural 1R1W SRAM model.
package behav_sram_pkg;

  typedef enum logic {SRAM_INIT, SRAM_READY} sram_state_e;

  localparam int RDW_READ_FIRST    = 0;
  localparam int RDW_WRITE_THROUGH = 1;

  function automatic int sram_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/behav_sram_rd_pipe.sv
// Read-data pipeline: READ_LAT stages of valid+data; the last data stage holds
// its value between valid results so the read port keeps its last word.
module behav_sram_rd_pipe #(
  parameter int WIDTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q   [READ_LAT];
  logic [WIDTH-1:0] data_q    [READ_LAT];
  logic             src_valid [READ_LAT];
  logic [WIDTH-1:0] src_data  [READ_LAT];

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < READ_LAT; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      for (int i = 0; i < READ_LAT; i++) valid_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < READ_LAT; i++) valid_q[i] <= src_valid[i];
    end
  end

  // Only the output stage is gated by valid; inner stages just shift.
  always_ff @(posedge clock) begin
    for (int i = 0; i < READ_LAT - 1; i++) data_q[i] <= src_data[i];
    if (!clear_n) begin
      data_q[READ_LAT-1] <= '0;
    end else if (src_valid[READ_LAT-1]) begin
      data_q[READ_LAT-1] <= src_data[READ_LAT-1];
    end
  end

  assign out_valid = valid_q[READ_LAT-1];
  assign out_data  = data_q[READ_LAT-1];

endmodule

// File: rtl/behav_sram_1r1w_ext.sv
// Behavioural 1R1W SRAM with init sweep, masked writes, read latency pipe and RDW policy.
// Define BEHAV_SRAM_GARBAGE_EN to drive random data on R0_rdata whenever R0_valid is low.
module behav_sram_1r1w_ext
  import behav_sram_pkg::*;
#(
  parameter int               DEPTH     = 512,
  parameter int               WIDTH     = 256,
  parameter int               MASK_GRAN = 8,
  parameter int               READ_LAT  = 1,
  parameter int               RDW_MODE  = RDW_READ_FIRST,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  localparam int              ADDR_W    = sram_addr_w(DEPTH),
  localparam int              LANES     = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_busy,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic              R0_valid,
  output logic [WIDTH-1:0]  R0_rdata,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [LANES-1:0]  W0_mask,
  input  logic [WIDTH-1:0]  W0_data,
  output logic              oor_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("behav_sram_1r1w_ext: WIDTH %0d not a multiple of MASK_GRAN %0d", WIDTH, MASK_GRAN);
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("behav_sram_1r1w_ext: READ_LAT %0d outside 1..4", READ_LAT);
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_THROUGH) begin : g_bad_rdw
    $error("behav_sram_1r1w_ext: RDW_MODE %0d unsupported", RDW_MODE);
  end

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic             ready;
  logic             rd_in_range, wr_in_range;
  logic             rd_fire, wr_fire, rdw_hit;
  logic [WIDTH-1:0] wr_bits, wr_merged, rd_word;
  logic             oor_q;
  logic             pipe_valid;
  logic [WIDTH-1:0] pipe_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= SRAM_INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SRAM_INIT) sweep_cnt_q <= sweep_cnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    init_busy = !reset_n || (state_q == SRAM_INIT);
    ready     = reset_n && (state_q == SRAM_READY);
    if (state_q == SRAM_INIT && sweep_cnt_q == LAST_ADDR) state_d = SRAM_READY;
  end

  assign rd_in_range = 32'(R0_addr) < DEPTH;
  assign wr_in_range = 32'(W0_addr) < DEPTH;
  assign rd_fire     = ready && R0_en;
  assign wr_fire     = ready && W0_en && wr_in_range && (|W0_mask);
  assign rdw_hit     = wr_fire && (W0_addr == R0_addr) && (RDW_MODE == RDW_WRITE_THROUGH);

  always_comb begin
    wr_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
    end
  end

  // Write-through reuses the merged write word so both ports see identical lanes.
  always_comb begin
    wr_merged = (mem[W0_addr] & ~wr_bits) | (W0_data & wr_bits);
    rd_word   = '0;
    if (rd_in_range) rd_word = rdw_hit ? wr_merged : mem[R0_addr];
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state_q == SRAM_INIT) begin
        mem[sweep_cnt_q] <= INIT_VAL;
      end else if (wr_fire) begin
        mem[W0_addr] <= wr_merged;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= ready && ((R0_en && !rd_in_range) || (W0_en && !wr_in_range));
    end
  end

  assign oor_err = oor_q;

  behav_sram_rd_pipe #(
    .WIDTH    (WIDTH),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clock     (clock),
    .clear_n   (reset_n),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign R0_valid = pipe_valid;

`ifdef BEHAV_SRAM_GARBAGE_EN
  localparam int GARBAGE_W = ((WIDTH + 31) / 32) * 32;
  logic [GARBAGE_W-1:0] garbage_q;

  always_ff @(posedge clock) begin
    for (int i = 0; i < GARBAGE_W / 32; i++) garbage_q[i*32 +: 32] <= $random;
  end

  assign R0_rdata = pipe_valid ? pipe_data : garbage_q[WIDTH-1:0];
`else
  assign R0_rdata = pipe_data;
`endif

endmodule

// File: tb/tb_behav_sram_1r1w_ext.sv
// Bench for behav_sram_1r1w_ext: two instances (DEPTH 8/LAT 1/read-first and DEPTH 6/LAT 3/write-through)
// share one stimulus stream and are checked against a word-level memory model.
module tb_behav_sram_1r1w_ext;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, R0_en, W0_en;
  logic [2:0]  R0_addr, W0_addr;
  logic [3:0]  W0_mask;
  logic [31:0] W0_data;
  logic        init_busy_a, R0_valid_a, oor_err_a;
  logic        init_busy_b, R0_valid_b, oor_err_b;
  logic [31:0] R0_rdata_a, R0_rdata_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          m_depth [2];
  int          m_lat   [2];
  int          m_rdw   [2];
  logic [31:0] m_init  [2];
  logic [31:0] mm      [2][8];
  int          init_left [2];
  logic        pend_v  [2][8];
  logic [31:0] pend_d  [2][8];
  logic [31:0] last_d  [2];
  logic [34:0] exp_pk  [2];
  logic [34:0] obs_pk  [2];

  behav_sram_1r1w_ext #(
    .DEPTH(8), .WIDTH(32), .MASK_GRAN(8), .READ_LAT(1), .RDW_MODE(0), .INIT_VAL(32'h0000_00A5)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .init_busy(init_busy_a),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_valid(R0_valid_a), .R0_rdata(R0_rdata_a),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_mask(W0_mask), .W0_data(W0_data),
    .oor_err(oor_err_a)
  );

  behav_sram_1r1w_ext #(
    .DEPTH(6), .WIDTH(32), .MASK_GRAN(8), .READ_LAT(3), .RDW_MODE(1), .INIT_VAL(32'h5A5A_00C3)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .init_busy(init_busy_b),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_valid(R0_valid_b), .R0_rdata(R0_rdata_b),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_mask(W0_mask), .W0_data(W0_data),
    .oor_err(oor_err_b)
  );

  always_comb begin
    obs_pk[0] = {init_busy_a, R0_valid_a, oor_err_a, R0_rdata_a};
    obs_pk[1] = {init_busy_b, R0_valid_b, oor_err_b, R0_rdata_b};
  end

  // Drive one cycle, predict each memory's post-edge outputs, then step past the edge.
  task automatic drive_cycle(input logic rn, input logic re, input logic [2:0] ra,
                             input logic we, input logic [2:0] wa,
                             input logic [3:0] wm, input logic [31:0] wd);
    logic [31:0] merged, rd;
    logic        v, oor;
    int          slot, due;
    reset_n = rn; R0_en = re; R0_addr = ra;
    W0_en = we; W0_addr = wa; W0_mask = wm; W0_data = wd;
    slot = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      v = 1'b0;
      oor = 1'b0;
      if (!rn) begin
        init_left[k] = m_depth[k];
        for (int s = 0; s < 8; s++) pend_v[k][s] = 1'b0;
        last_d[k] = '0;
      end else if (init_left[k] > 0) begin
        mm[k][m_depth[k] - init_left[k]] = m_init[k];
        init_left[k]--;
      end else begin
        merged = mm[k][wa];
        for (int l = 0; l < 4; l++) if (wm[l]) merged[8*l +: 8] = wd[8*l +: 8];
        if (re) begin
          if (int'(ra) >= m_depth[k]) rd = '0;
          else if (m_rdw[k] == 1 && we && wa == ra) rd = merged;
          else rd = mm[k][ra];
          due = (cyc + m_lat[k] - 1) % 8;
          pend_v[k][due] = 1'b1;
          pend_d[k][due] = rd;
        end
        if (we && int'(wa) < m_depth[k]) mm[k][wa] = merged;
        oor = (re && int'(ra) >= m_depth[k]) || (we && int'(wa) >= m_depth[k]);
      end
      if (rn) begin
        v = pend_v[k][slot];
        if (v) last_d[k] = pend_d[k][slot];
        pend_v[k][slot] = 1'b0;
      end
      exp_pk[k] = {(!rn || init_left[k] > 0), v, oor, last_d[k]};
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    int first_free [2];
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), $urandom);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL reset dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
    end
    first_free[0] = -1;
    first_free[1] = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 5) drive_cycle(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 4'hF, $urandom);
      else idle_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL init_sweep dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
        if (first_free[k] < 0 && !obs_pk[k][34]) first_free[k] = c;
      end
    end
    checks++;
    if (first_free[0] !== 8) begin
      errors++;
      $display("FAIL init_len dut=0 got %0d cycles expected 8", first_free[0]);
    end
    checks++;
    if (first_free[1] !== 6) begin
      errors++;
      $display("FAIL init_len dut=1 got %0d cycles expected 6", first_free[1]);
    end
  endtask

  task automatic test_init_values();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive_cycle(1'b1, 1'b1, 3'(c), 1'b0, 3'd0, 4'h0, 32'h0);
      else idle_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL init_values dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
      if (c == 7) begin
        checks++;
        if (R0_rdata_a !== 32'h0000_00A5) begin
          errors++;
          $display("FAIL init_word7 got %h expected 000000a5", R0_rdata_a);
        end
      end
    end
  endtask

  task automatic test_mask();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive_cycle(1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 4'hF, 32'h1122_3344);
        1: drive_cycle(1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 4'h5, 32'hAABB_CCDD);
        2: drive_cycle(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 4'h0, 32'h0);
        default: idle_cycle();
      endcase
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL mask dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
    end
    checks++;
    if (R0_rdata_a !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL mask_word dut=0 got %h expected 11bb33dd", R0_rdata_a);
    end
    checks++;
    if (R0_rdata_b !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL mask_word dut=1 got %h expected 11bb33dd", R0_rdata_b);
    end
  endtask

  task automatic test_latency();
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive_cycle(1'b1, 1'b1, 3'(c + 1), 1'b0, 3'd0, 4'h0, 32'h0);
      else idle_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL latency dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
    end
  endtask

  task automatic test_rdw();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive_cycle(1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 4'hF, 32'h0);
        1: drive_cycle(1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 4'h3, 32'hFFFF_FFFF);
        2: drive_cycle(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 4'h0, 32'h0);
        default: idle_cycle();
      endcase
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL rdw dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
    end
  endtask

  task automatic test_oor();
    int pulses [2];
    pulses[0] = 0;
    pulses[1] = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) drive_cycle(1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 4'hF, 32'hDEAD_BEEF);
      else if (c == 1) drive_cycle(1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 4'h0, 32'h0);
      else if (c < 8) drive_cycle(1'b1, 1'b1, 3'(c - 2), 1'b0, 3'd0, 4'h0, 32'h0);
      else idle_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL oor dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
        if (obs_pk[k][32]) pulses[k]++;
      end
    end
    checks++;
    if (pulses[1] !== 2) begin
      errors++;
      $display("FAIL oor_pulses dut=1 got %0d expected 2", pulses[1]);
    end
    checks++;
    if (pulses[0] !== 0) begin
      errors++;
      $display("FAIL oor_pulses dut=0 got %0d expected 0", pulses[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      drive_cycle(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), $urandom);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL back_to_back dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int first_free [2];
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'h0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'h0, 32'h0);
    for (int c = 0; c < 3; c++) idle_cycle();
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'h0, 32'h0);
    first_free[0] = -1;
    first_free[1] = -1;
    for (int c = 1; c <= 12; c++) begin
      idle_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pk[k] !== exp_pk[k]) begin
          errors++;
          $display("FAIL mid_sweep dut=%0d cyc=%0d got %h expected %h", k, cyc, obs_pk[k], exp_pk[k]);
        end
        if (first_free[k] < 0 && !obs_pk[k][34]) first_free[k] = c;
      end
    end
    checks++;
    if (first_free[0] !== 8) begin
      errors++;
      $display("FAIL mid_sweep_len dut=0 got %0d cycles expected 8", first_free[0]);
    end
    checks++;
    if (first_free[1] !== 6) begin
      errors++;
      $display("FAIL mid_sweep_len dut=1 got %0d cycles expected 6", first_free[1]);
    end
  endtask

  initial begin
    m_depth[0] = 8;  m_lat[0] = 1; m_rdw[0] = 0; m_init[0] = 32'h0000_00A5;
    m_depth[1] = 6;  m_lat[1] = 3; m_rdw[1] = 1; m_init[1] = 32'h5A5A_00C3;
    reset_n = 1'b0; R0_en = 1'b0; R0_addr = '0;
    W0_en = 1'b0; W0_addr = '0; W0_mask = '0; W0_data = '0;
    test_reset();
    test_init_values();
    test_mask();
    test_latency();
    test_rdw();
    test_oor();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
